// File: rtl/tri_bus_arbiter_if.sv
// Handshake and status bundle for the tri-state bus transmit controller.
//   src_valid  per-source word available        (source -> arbiter)
//   src_data   packed source words, i at [i*DW]  (source -> arbiter)
//   src_ready  per-source beat accepted          (arbiter -> source)
//   bus_oe     one-hot tri-buffer enables        (arbiter -> bus)
//   cap_en     receiver capture strobe           (arbiter -> receiver)
//   owner      current/last grantee index        (arbiter -> status)
//   busy       high in DRIVE or TURN             (arbiter -> status)
//   state_dbg  FSM state, 0=IDLE 1=DRIVE 2=TURN  (arbiter -> debug)
// Handshake: a beat transfers on a rising clock edge where src_valid[i] and
// src_ready[i] are both high; a source holds valid and data stable until then,
// and dropping valid before ready ends the current burst.
interface tri_bus_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_SRC    = 2
);
    localparam int OW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ready;
    logic [NUM_SRC-1:0]            bus_oe;
    logic                          cap_en;
    logic [OW-1:0]                 owner;
    logic                          busy;
    logic [1:0]                    state_dbg;

    modport master (
        input  src_valid, src_data,
        output src_ready, bus_oe, cap_en, owner, busy, state_dbg
    );

    modport slave (
        output src_valid, src_data,
        input  src_ready, bus_oe, cap_en, owner, busy, state_dbg
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Transmit-side controller for a shared tri-state data bus. Round-robin
// arbitration among NUM_SRC valid/ready sources; the winner drives bus_data
// through a one-hot output enable, with a turnaround gap after every grant.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       tri_bus_arbiter_if.master (sources, enables, strobe, status)
//   bus_data  tri-state bus word, high impedance whenever no enable is high
// The tri-state net is a plain port so resolution happens at the net level.
module tri_bus_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_SRC     = 2,
    parameter int MAX_BURST   = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tri_bus_arbiter_if.master     bus,
    output wire  [DATA_WIDTH-1:0] bus_data
);
    localparam int OW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [OW-1:0] grant, grant_n;
    logic [OW-1:0] rr_ptr, rr_n;
    logic [BW-1:0] beat_cnt, beat_n;
    logic [TW-1:0] turn_cnt, turn_n;

    logic                  found;
    logic                  release_now;
    int                    idx;
    logic [NUM_SRC-1:0]    oe;
    logic [DATA_WIDTH-1:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            rr_ptr   <= rr_n;
            beat_cnt <= beat_n;
            turn_cnt <= turn_n;
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        rr_n        = rr_ptr;
        beat_n      = beat_cnt;
        turn_n      = turn_cnt;
        found       = 1'b0;
        release_now = 1'b0;
        idx         = 0;
        case (state)
            IDLE: begin
                // Scan starting at the pointer, wrapping, first valid wins.
                for (int i = 0; i < NUM_SRC; i++) begin
                    idx = int'(rr_ptr) + i;
                    if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                    if (!found && bus.src_valid[idx]) begin
                        found   = 1'b1;
                        grant_n = OW'(idx);
                    end
                end
                if (found) begin
                    state_n = DRIVE;
                    beat_n  = '0;
                end
            end
            DRIVE: begin
                if (!bus.src_valid[grant]) begin
                    // Source went quiet: this cycle carries no beat.
                    release_now = 1'b1;
                end else begin
                    beat_n = beat_cnt + 1'b1;
                    if (beat_n == BW'(MAX_BURST)) release_now = 1'b1;
                end
                if (release_now) begin
                    state_n = TURN;
                    turn_n  = '0;
                    rr_n    = (grant == OW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt == TW'(TURN_CYCLES - 1)) state_n = IDLE;
                else                                  turn_n  = turn_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Enables come straight from the registered state and grant, so reset
    // removes every driver in the same cycle it is asserted.
    always_comb begin
        oe = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            oe[i] = (state == DRIVE) && (grant == OW'(i));
        end
    end

    assign word          = bus.src_data[grant*DATA_WIDTH +: DATA_WIDTH];
    assign bus_data      = (|oe) ? word : {DATA_WIDTH{1'bz}};
    assign bus.bus_oe    = oe;
    assign bus.src_ready = oe;
    assign bus.cap_en    = (state == DRIVE) && bus.src_valid[grant];
    assign bus.busy      = (state != IDLE);
    assign bus.owner     = grant;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;
    localparam int DW   = 64;
    localparam int NSRC = 2;
    localparam int MAXB = 4;
    localparam int TURN = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    wire  [DW-1:0] bus_data;
    int            n_cmp = 0;
    int            n_fail = 0;

    tri_bus_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NSRC)) bus_if ();

    tri_bus_arbiter #(
        .DATA_WIDTH(DW), .NUM_SRC(NSRC), .MAX_BURST(MAXB), .TURN_CYCLES(TURN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          rst_n;
        logic [1:0]    valid;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    oe;
        logic [1:0]    rdy;
        logic          cap;
        logic          owner;
        logic          busy;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vq[$];
    logic [DW-1:0] exp_q[$];

    task automatic add_vec(input logic r, input logic [1:0] v, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1, input logic [1:0] oe,
                           input logic cap, input logic own, input logic busy,
                           input logic [DW-1:0] data);
        vec_t e;
        e.rst_n = r; e.valid = v; e.d0 = d0; e.d1 = d1;
        e.oe = oe; e.rdy = oe; e.cap = cap; e.owner = own; e.busy = busy; e.data = data;
        vq.push_back(e);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int src, input int seq);
        return {32'(src), 32'(seq)};
    endfunction

    // Both sources request continuously from reset; grants alternate 0,1,0,1
    // with MAXB beats each and an idle gap of TURN plus the IDLE cycle.
    task automatic run_contention();
        int seq[2];
        int cnt[2];
        int gap;
        int cycles;
        bit seen_drive;
        logic [1:0] took;
        logic [DW-1:0] exp;
        rst_n = 1'b0;
        bus_if.src_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seq = '{0, 0};
        cnt = '{0, 0};
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < MAXB; k++) begin
                exp_q.push_back(mk_word(r % 2, cnt[r % 2]));
                cnt[r % 2]++;
            end
        end
        bus_if.src_valid = 2'b11;
        bus_if.src_data  = {mk_word(1, seq[1]), mk_word(0, seq[0])};
        gap = 0;
        cycles = 0;
        seen_drive = 1'b0;
        while (exp_q.size() > 0 && cycles < 100) begin
            @(negedge clk);
            check("oe_onehot0", 64'($onehot0(bus_if.bus_oe)), 64'd1);
            if (bus_if.cap_en) check("cap_implies_oe", 64'(|bus_if.bus_oe), 64'd1);
            if (|bus_if.bus_oe) begin
                if (seen_drive && gap > 0) check("turn_gap", 64'(gap), 64'(TURN + 1));
                gap = 0;
                seen_drive = 1'b1;
            end else begin
                gap++;
            end
            if (bus_if.cap_en) begin
                exp = exp_q.pop_front();
                check("capture_known", 64'($isunknown(bus_data)), 64'd0);
                check("capture_word", bus_data, exp);
            end
            took = bus_if.src_ready & bus_if.src_valid;
            @(posedge clk); #1;
            if (took[0]) seq[0]++;
            if (took[1]) seq[1]++;
            bus_if.src_data = {mk_word(1, seq[1]), mk_word(0, seq[0])};
            cycles++;
        end
        check("contention_all_captured", 64'(exp_q.size()), 64'd0);
        check("contention_beats_src0", 64'(seq[0]), 64'(2 * MAXB));
        check("contention_beats_src1", 64'(seq[1]), 64'(2 * MAXB));
        bus_if.src_valid = 2'b00;
    endtask

    localparam logic [DW-1:0] W0 = 64'hA5A5_0000_0000_0000;
    localparam logic [DW-1:0] W1 = 64'hA5A5_0000_0000_0001;
    localparam logic [DW-1:0] W2 = 64'hA5A5_0000_0000_0002;
    localparam logic [DW-1:0] W3 = 64'hA5A5_0000_0000_0003;
    localparam logic [DW-1:0] W4 = 64'hA5A5_0000_0000_0004;
    localparam logic [DW-1:0] W5 = 64'hA5A5_0000_0000_0005;
    localparam logic [DW-1:0] W6 = 64'hA5A5_0000_0000_0006;
    localparam logic [DW-1:0] W7 = 64'hA5A5_0000_0000_0007;
    localparam logic [DW-1:0] X0 = 64'h5A5A_1111_0000_0000;
    localparam logic [DW-1:0] X1 = 64'h5A5A_1111_0000_0001;
    localparam logic [DW-1:0] X2 = 64'h5A5A_1111_0000_0002;

    initial begin
        bus_if.src_valid = 2'b11;
        bus_if.src_data  = '0;

        //       rst  valid  d0  d1   oe    cap own busy data
        add_vec(1'b0, 2'b11, '0, '0,  2'b00, 0, 0, 0, '0);  // reset with both requesting
        add_vec(1'b1, 2'b10, '0, W0,  2'b00, 0, 0, 0, '0);  // IDLE sees src1
        add_vec(1'b1, 2'b10, '0, W0,  2'b10, 1, 1, 1, W0);
        add_vec(1'b1, 2'b10, '0, W1,  2'b10, 1, 1, 1, W1);
        add_vec(1'b1, 2'b10, '0, W2,  2'b10, 1, 1, 1, W2);
        add_vec(1'b1, 2'b10, '0, W3,  2'b10, 1, 1, 1, W3);  // 4th beat, forced release
        add_vec(1'b1, 2'b10, '0, W4,  2'b00, 0, 1, 1, '0);  // TURN
        add_vec(1'b1, 2'b10, '0, W4,  2'b00, 0, 1, 0, '0);  // IDLE, re-grant src1
        add_vec(1'b1, 2'b10, '0, W4,  2'b10, 1, 1, 1, W4);
        add_vec(1'b1, 2'b10, '0, W5,  2'b10, 1, 1, 1, W5);
        add_vec(1'b1, 2'b00, '0, W5,  2'b10, 0, 1, 1, '0);  // zero-beat cycle
        add_vec(1'b1, 2'b00, '0, '0,  2'b00, 0, 1, 1, '0);  // TURN
        add_vec(1'b1, 2'b01, X0, '0,  2'b00, 0, 1, 0, '0);  // IDLE sees src0
        add_vec(1'b1, 2'b01, X0, '0,  2'b01, 1, 0, 1, X0);
        add_vec(1'b1, 2'b01, X1, '0,  2'b01, 1, 0, 1, X1);
        add_vec(1'b1, 2'b00, '0, '0,  2'b01, 0, 0, 1, '0);  // early release
        add_vec(1'b1, 2'b11, X2, W6,  2'b00, 0, 0, 1, '0);  // TURN, requests held
        add_vec(1'b1, 2'b11, X2, W6,  2'b00, 0, 0, 0, '0);  // IDLE: pointer at src1
        add_vec(1'b1, 2'b11, X2, W6,  2'b10, 1, 1, 1, W6);
        add_vec(1'b0, 2'b11, X2, W7,  2'b00, 0, 0, 0, '0);  // reset at beat 2
        add_vec(1'b1, 2'b11, X2, W7,  2'b00, 0, 0, 0, '0);  // IDLE after reset
        add_vec(1'b1, 2'b11, X2, W7,  2'b01, 1, 0, 1, X2);  // src0 first after reset

        @(posedge clk); #1;
        foreach (vq[i]) begin
            rst_n            = vq[i].rst_n;
            bus_if.src_valid = vq[i].valid;
            bus_if.src_data  = {vq[i].d1, vq[i].d0};
            @(negedge clk);
            check($sformatf("v%0d_bus_oe", i),    64'(bus_if.bus_oe),    64'(vq[i].oe));
            check($sformatf("v%0d_src_ready", i), 64'(bus_if.src_ready), 64'(vq[i].rdy));
            check($sformatf("v%0d_cap_en", i),    64'(bus_if.cap_en),    64'(vq[i].cap));
            check($sformatf("v%0d_owner", i),     64'(bus_if.owner),     64'(vq[i].owner));
            check($sformatf("v%0d_busy", i),      64'(bus_if.busy),      64'(vq[i].busy));
            if (vq[i].cap) check($sformatf("v%0d_bus_data", i), bus_data, vq[i].data);
            @(posedge clk); #1;
        end

        run_contention();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
